// File: rtl/axi_lite_regif.sv
// axi_lite_regif
//   AXI4-Lite slave bridging a bus master onto a word-indexed register bank.
//   One outstanding write and one outstanding read; the two paths run
//   independently. AW and W may be accepted in either order. Addresses that
//   decode outside the bank answer SLVERR and raise no register strobe.
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_aw*/o_awready        write-address channel
//   i_w*/o_wready          write-data channel (data + byte strobes)
//   o_b*/i_bready          write-response channel
//   i_ar*/o_arready        read-address channel
//   o_r*/i_rready          read-data channel
//   o_reg_wr/widx/wdata/wstrb   one-cycle register write strobe and payload
//   o_reg_rd/ridx, i_reg_rdata  one-cycle register read strobe, index, data
module axi_lite_regif #(
  parameter int unsigned    AW     = 32,
  parameter int unsigned    DW     = 32,
  parameter int unsigned    NREG   = 16,
  parameter logic [AW-1:0]  BASE   = '0,
  parameter int unsigned    RD_LAT = 1,
  localparam int unsigned   IW     = $clog2(NREG),
  localparam int unsigned   SW     = DW / 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  // write address
  input  logic          i_awvalid,
  output logic          o_awready,
  input  logic [AW-1:0] i_awaddr,
  // write data
  input  logic          i_wvalid,
  output logic          o_wready,
  input  logic [DW-1:0] i_wdata,
  input  logic [SW-1:0] i_wstrb,
  // write response
  output logic          o_bvalid,
  input  logic          i_bready,
  output logic [1:0]    o_bresp,
  // read address
  input  logic          i_arvalid,
  output logic          o_arready,
  input  logic [AW-1:0] i_araddr,
  // read data
  output logic          o_rvalid,
  input  logic          i_rready,
  output logic [DW-1:0] o_rdata,
  output logic [1:0]    o_rresp,
  // register bank side
  output logic          o_reg_wr,
  output logic [IW-1:0] o_reg_widx,
  output logic [DW-1:0] o_reg_wdata,
  output logic [SW-1:0] o_reg_wstrb,
  output logic          o_reg_rd,
  output logic [IW-1:0] o_reg_ridx,
  input  logic [DW-1:0] i_reg_rdata
);

  localparam int unsigned BW       = $clog2(SW);
  localparam logic [1:0]  RESP_OK  = 2'b00;
  localparam logic [1:0]  RESP_ERR = 2'b10;
  localparam logic [1:0]  CNT_INIT = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_STRB, R_WAIT, R_RESP} rstate_t;

  // ---------------------------------------------------------------- decode
  // Word index relative to BASE; byte-offset bits are shifted away and the
  // subtraction wraps modulo 2^AW so addresses below BASE become misses.
  logic [AW-1:0] w_aw_word;
  logic [AW-1:0] w_ar_word;
  logic          w_aw_hit;
  logic          w_ar_hit;

  assign w_aw_word = (i_awaddr - BASE) >> BW;
  assign w_ar_word = (i_araddr - BASE) >> BW;
  assign w_aw_hit  = (w_aw_word < AW'(NREG));
  assign w_ar_hit  = (w_ar_word < AW'(NREG));

  // ------------------------------------------------------------ write path
  wstate_t       r_wstate;
  wstate_t       w_wstate_nxt;
  logic          r_aw_held;
  logic          r_w_held;
  logic          r_aw_hit;
  logic [IW-1:0] r_widx;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;
  logic [1:0]    r_bresp;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_b_hs;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_wstate <= W_IDLE;
    else       r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    o_awready    = 1'b0;
    o_wready     = 1'b0;
    o_bvalid     = 1'b0;
    o_reg_wr     = 1'b0;
    w_aw_hs      = 1'b0;
    w_w_hs       = 1'b0;
    w_b_hs       = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        o_awready = !r_aw_held;
        o_wready  = !r_w_held;
        w_aw_hs   = i_awvalid && !r_aw_held;
        w_w_hs    = i_wvalid && !r_w_held;
        if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs))
          w_wstate_nxt = W_EXEC;
      end
      W_EXEC: begin
        // Strobe is masked during reset so a transaction dropped by reset
        // never reaches the register bank.
        o_reg_wr     = r_aw_hit && !i_rst;
        w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        o_bvalid = 1'b1;
        if (i_bready) begin
          w_b_hs       = 1'b1;
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_hit  <= 1'b0;
      r_widx    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_hit  <= w_aw_hit;
        r_widx    <= w_aw_word[IW-1:0];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= i_wdata;
        r_wstrb  <= i_wstrb;
      end
      if (r_wstate == W_EXEC)
        r_bresp <= r_aw_hit ? RESP_OK : RESP_ERR;
      if (w_b_hs) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

  assign o_reg_widx  = r_widx;
  assign o_reg_wdata = r_wdata;
  assign o_reg_wstrb = r_wstrb;
  assign o_bresp     = r_bresp;

  // ------------------------------------------------------------- read path
  rstate_t       r_rstate;
  rstate_t       w_rstate_nxt;
  logic          r_ar_hit;
  logic [IW-1:0] r_ridx;
  logic [1:0]    r_rcnt;
  logic [DW-1:0] r_rdata;
  logic [1:0]    r_rresp;
  logic          w_ar_hs;
  logic          w_capture;
  logic          w_cnt_load;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    o_arready    = 1'b0;
    o_rvalid     = 1'b0;
    o_reg_rd     = 1'b0;
    w_ar_hs      = 1'b0;
    w_capture    = 1'b0;
    w_cnt_load   = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        o_arready = 1'b1;
        if (i_arvalid) begin
          w_ar_hs      = 1'b1;
          w_rstate_nxt = R_STRB;
        end
      end
      R_STRB: begin
        o_reg_rd = r_ar_hit && !i_rst;
        if (RD_LAT == 0) begin
          w_capture    = 1'b1;
          w_rstate_nxt = R_RESP;
        end else begin
          w_cnt_load   = 1'b1;
          w_rstate_nxt = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_rcnt == 2'd0) begin
          w_capture    = 1'b1;
          w_rstate_nxt = R_RESP;
        end
      end
      R_RESP: begin
        o_rvalid = 1'b1;
        if (i_rready) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ar_hit <= 1'b0;
      r_ridx   <= '0;
      r_rcnt   <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else begin
      if (w_ar_hs) begin
        r_ar_hit <= w_ar_hit;
        r_ridx   <= w_ar_word[IW-1:0];
      end
      if (w_cnt_load)
        r_rcnt <= CNT_INIT;
      else if ((r_rstate == R_WAIT) && (r_rcnt != 2'd0))
        r_rcnt <= r_rcnt - 2'd1;
      if (w_capture) begin
        r_rdata <= r_ar_hit ? i_reg_rdata : '0;
        r_rresp <= r_ar_hit ? RESP_OK : RESP_ERR;
      end
    end
  end

  assign o_reg_ridx = r_ridx;
  assign o_rdata    = r_rdata;
  assign o_rresp    = r_rresp;

endmodule

// File: tb/tb_axi_lite_regif.sv
module tb_axi_lite_regif;

  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned NREG   = 16;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned IW     = 4;
  localparam int unsigned SW     = 4;
  localparam logic [31:0] BASE   = 32'h0000_1000;

  logic          clk;
  logic          rst;
  logic          awvalid, awready;
  logic [AW-1:0] awaddr;
  logic          wvalid, wready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          bvalid, bready;
  logic [1:0]    bresp;
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic          rvalid, rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          reg_wr;
  logic [IW-1:0] reg_widx;
  logic [DW-1:0] reg_wdata;
  logic [SW-1:0] reg_wstrb;
  logic          reg_rd;
  logic [IW-1:0] reg_ridx;
  logic [DW-1:0] reg_rdata;

  axi_lite_regif #(
    .AW(AW), .DW(DW), .NREG(NREG), .BASE(BASE), .RD_LAT(RD_LAT)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_awvalid(awvalid), .o_awready(awready), .i_awaddr(awaddr),
    .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb),
    .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp),
    .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr),
    .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata), .o_rresp(rresp),
    .o_reg_wr(reg_wr), .o_reg_widx(reg_widx), .o_reg_wdata(reg_wdata),
    .o_reg_wstrb(reg_wstrb), .o_reg_rd(reg_rd), .o_reg_ridx(reg_ridx),
    .i_reg_rdata(reg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected-response queues (filled at issue time, drained by the monitor)
  logic [39:0] q_wr[$];   // {idx, data, strb}
  logic [1:0]  q_b[$];
  logic [3:0]  q_rd[$];
  logic [33:0] q_r[$];    // {data, resp}

  // Reference register contents, and the peripheral register file
  logic [31:0] model [NREG];
  logic [31:0] mem   [NREG];

  int cyc    = 0;
  int rd_cyc = -100;
  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral returns valid data only in the exact cycle RD_LAT after reg_rd
  assign reg_rdata = (cyc == rd_cyc + int'(RD_LAT)) ? mem[reg_ridx] : 32'hDEAD_BEEF;

  int bmode = 0;  // 0: ready high, 1: random, 2: ready low
  int rmode = 0;
  always @(posedge clk) begin
    #1;
    bready = (bmode == 0) ? 1'b1 : (bmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    rready = (rmode == 0) ? 1'b1 : (rmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
  end

  // ---------------------------------------------------------------- monitor
  int n_wr = 0, n_rd = 0;
  int last_wr_cyc = 0, last_rd_cyc = 0, last_b_cyc = 0, last_r_cyc = 0;
  bit prev_bv = 0, prev_rv = 0;
  bit aw_pend = 0, w_pend = 0, ar_pend = 0;

  always @(negedge clk) begin
    if (rst) begin
      aw_pend = 0; w_pend = 0; ar_pend = 0; prev_bv = 0; prev_rv = 0;
    end else begin
      if (aw_pend) chk("awready_low_while_held", awready, 0);
      if (w_pend)  chk("wready_low_while_held", wready, 0);
      if (ar_pend) chk("arready_low_while_busy", arready, 0);
      if (awvalid && awready) aw_pend = 1;
      if (wvalid && wready)   w_pend  = 1;
      if (arvalid && arready) ar_pend = 1;

      if (reg_wr) begin
        n_wr++;
        last_wr_cyc = cyc;
        if (q_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL reg_wr_unexpected: got idx %0d with no write expected", reg_widx);
        end else
          chk("reg_wr_payload", {reg_widx, reg_wdata, reg_wstrb}, q_wr.pop_front());
        for (int b = 0; b < 4; b++)
          if (reg_wstrb[b]) mem[reg_widx][8*b +: 8] = reg_wdata[8*b +: 8];
      end

      if (reg_rd) begin
        n_rd++;
        last_rd_cyc = cyc;
        rd_cyc      = cyc;
        if (q_rd.size() == 0) begin
          checks++; failures++;
          $display("FAIL reg_rd_unexpected: got idx %0d with no read expected", reg_ridx);
        end else
          chk("reg_rd_idx", reg_ridx, q_rd.pop_front());
      end

      if (bvalid && !prev_bv) last_b_cyc = cyc;
      prev_bv = bvalid;
      if (bvalid && bready) begin
        if (q_b.size() == 0) begin
          checks++; failures++;
          $display("FAIL bresp_unexpected: got 0x%0h with no response expected", bresp);
        end else
          chk("bresp", bresp, q_b.pop_front());
        aw_pend = 0; w_pend = 0;
      end

      if (rvalid && !prev_rv) last_r_cyc = cyc;
      prev_rv = rvalid;
      if (rvalid && rready) begin
        if (q_r.size() == 0) begin
          checks++; failures++;
          $display("FAIL rresp_unexpected: got 0x%0h with no response expected", {rdata, rresp});
        end else
          chk("rdata_rresp", {rdata, rresp}, q_r.pop_front());
        ar_pend = 0;
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  function automatic void decode(input logic [31:0] addr, output bit hit, output int idx);
    logic [31:0] off;
    off = addr - BASE;
    hit = (off / 4) < NREG;
    idx = hit ? int'(off / 4) : 0;
  endfunction

  task automatic send_aw(input logic [31:0] a, input int dly, output int hs);
    hs = -1;
    repeat (dly) begin @(posedge clk); #1; end
    awaddr = a; awvalid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (awready) begin hs = cyc; break; end
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("aw_handshake", hs >= 0, 1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly, output int hs);
    hs = -1;
    repeat (dly) begin @(posedge clk); #1; end
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wready) begin hs = cyc; break; end
    end
    @(posedge clk); #1;
    wvalid = 1'b0;
    chk("w_handshake", hs >= 0, 1);
  endtask

  task automatic send_ar(input logic [31:0] a, input int dly, output int hs);
    hs = -1;
    repeat (dly) begin @(posedge clk); #1; end
    araddr = a; arvalid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (arready) begin hs = cyc; break; end
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("ar_handshake", hs >= 0, 1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                          input int awd, input int wd, output int aw_hs, output int w_hs);
    bit hit; int idx; int a_h, w_h; bit got;
    decode(addr, hit, idx);
    q_b.push_back(hit ? 2'b00 : 2'b10);
    if (hit) begin
      q_wr.push_back({4'(idx), d, s});
      for (int b = 0; b < 4; b++)
        if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    end
    fork
      send_aw(addr, awd, a_h);
      send_w(d, s, wd, w_h);
    join
    aw_hs = a_h; w_hs = w_h;
    got = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bvalid && bready) begin got = 1; break; end
    end
    @(posedge clk); #1;
    chk("b_handshake", got, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int ard, output int ar_hs);
    bit hit; int idx; int a_h; bit got;
    decode(addr, hit, idx);
    q_r.push_back({hit ? model[idx] : 32'h0, hit ? 2'b00 : 2'b10});
    if (hit) q_rd.push_back(4'(idx));
    send_ar(addr, ard, a_h);
    ar_hs = a_h;
    got = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (rvalid && rready) begin got = 1; break; end
    end
    @(posedge clk); #1;
    chk("r_handshake", got, 1);
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    int ah, wh, rh, n0, r0, wword, rword;
    logic [31:0] waddr, raddr;
    logic [35:0] snap;
    bit ok;

    rst = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    bready = 1'b1; rready = 1'b1;
    for (int i = 0; i < int'(NREG); i++) begin
      model[i] = 32'h1111_1111 * i;
      mem[i]   = 32'h1111_1111 * i;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, first cycle after reset
    @(negedge clk);
    chk("rst_readies", {awready, wready, arready}, 3'b111);
    chk("rst_valids_strobes", {bvalid, rvalid, reg_wr, reg_rd}, 4'b0000);
    chk("rst_resps", {bresp, rresp}, 4'b0000);
    chk("rst_rdata", rdata, 0);
    chk("rst_wpayload", {reg_wdata, reg_wstrb}, 0);
    chk("rst_indices", {reg_widx, reg_ridx}, 0);
    @(posedge clk); #1;

    // AW and W together
    do_write(BASE + 32'h8, 32'hA5A5_0001, 4'hF, 0, 0, ah, wh);
    chk("t1_same_cycle", ah - wh, 0);
    chk("t1_wr_latency", last_wr_cyc - ah, 1);
    chk("t1_bvalid_latency", last_b_cyc - ah, 2);

    // W first, AW three cycles later, partial strobe
    n0 = n_wr;
    do_write(BASE + 32'hC, 32'h1122_3344, 4'b0101, 3, 0, ah, wh);
    chk("t2_aw_after_w", ah - wh, 3);
    chk("t2_single_wr", n_wr - n0, 1);
    chk("t2_wr_latency", last_wr_cyc - ah, 1);

    // Read latency with RD_LAT=2
    do_write(BASE + 32'h4, 32'h0000_1234, 4'hF, 0, 0, ah, wh);
    do_read(BASE + 32'h4, 0, rh);
    chk("t3_rd_latency", last_rd_cyc - rh, 1);
    chk("t3_rvalid_latency", last_r_cyc - rh, 2 + RD_LAT);

    // Out-of-range and below-BASE accesses, byte offset ignored
    n0 = n_wr; r0 = n_rd;
    fork
      do_write(BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, ah, wh);
      do_read(BASE + 32'h40, 0, rh);
    join
    do_read(BASE - 32'h4, 1, rh);
    chk("t4_no_wr_on_miss", n_wr - n0, 0);
    chk("t4_no_rd_on_miss", n_rd - r0, 0);
    do_write(BASE + 32'h9, 32'h7700_0000, 4'b1000, 1, 0, ah, wh);
    do_read(BASE + 32'hB, 0, rh);

    // Back-pressure on both responses
    bmode = 2; rmode = 2;
    @(posedge clk); #1;
    fork
      do_write(BASE + 32'h14, 32'hCAFE_0014, 4'hF, 0, 1, ah, wh);
      do_read(BASE + 32'h18, 0, rh);
      begin
        ok = 0;
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          if (bvalid && rvalid) begin ok = 1; break; end
        end
        chk("t5_both_valid", ok, 1);
        snap = {bresp, rresp, rdata};
        repeat (5) begin
          @(negedge clk);
          chk("t5_bvalid_held", bvalid, 1);
          chk("t5_rvalid_held", rvalid, 1);
          chk("t5_payload_stable", {bresp, rresp, rdata}, snap);
          chk("t5_readies_low", {arready, awready, wready}, 3'b000);
        end
        bmode = 0; rmode = 0;
      end
    join

    // Randomised concurrent traffic
    bmode = 1; rmode = 1;
    for (int it = 0; it < 40; it++) begin
      wword = int'($urandom_range(0, 23)) - 4;
      rword = int'($urandom_range(0, 23)) - 4;
      if (rword == wword) rword = wword + 1;
      waddr = BASE + 32'(wword * 4 + int'($urandom_range(0, 3)));
      raddr = BASE + 32'(rword * 4 + int'($urandom_range(0, 3)));
      fork
        do_write(waddr, $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ah, wh);
        do_read(raddr, int'($urandom_range(0, 3)), rh);
      join
    end
    bmode = 0; rmode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < int'(NREG); i++)
      do_read(BASE + 32'(i * 4), 0, rh);

    // Reset right after an AW+W handshake drops the write
    n0 = n_wr;
    awaddr = BASE + 32'hC; wdata = 32'hBAD0_BAD0; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk("t6_accept", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("t6_no_wr_during_rst", reg_wr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_awready_after_rst", awready, 1);
    repeat (4) begin
      @(negedge clk);
      chk("t6_no_bvalid", bvalid, 0);
    end
    chk("t6_no_wr", n_wr - n0, 0);
    @(posedge clk); #1;
    do_read(BASE + 32'hC, 0, rh);

    chk("q_wr_drained", q_wr.size(), 0);
    chk("q_b_drained", q_b.size(), 0);
    chk("q_rd_drained", q_rd.size(), 0);
    chk("q_r_drained", q_r.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_lite_regif.md
# axi_lite_regif

AXI4-Lite slave that bridges a bus master to a parametrised, word-indexed register bank. Generalises the single-beat slave with independent AW/W acceptance in any order, byte strobes, a configurable register-read latency, and SLVERR for out-of-range addresses. Sits between the interconnect and a peripheral's register file; one outstanding write and one outstanding read, which may run concurrently.

## Interface
- AW, 32, AXI address width
- DW, 32, data width; 32 or 64
- NREG, 16, number of DW-wide registers decoded; 2..256
- BASE, 0, byte base address of register 0; NREG*DW/8-aligned
- RD_LAT, 1, cycles from reg_rd to valid reg_rdata; 0..3
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- awvalid/awready  in/out  1  write-address handshake; awaddr  in  AW
- wvalid/wready  in/out  1  write-data handshake; wdata  in  DW; wstrb  in  DW/8
- bvalid/bready  out/in  1  write response; bresp  out  2
- arvalid/arready  in/out  1  read-address handshake; araddr  in  AW
- rvalid/rready  out/in  1  read response; rdata  out  DW; rresp  out  2
- reg_wr  out  1  one-cycle write strobe
- reg_widx  out  IW=clog2(NREG)  write register index
- reg_wdata  out  DW; reg_wstrb  out  DW/8  held data and strobes
- reg_rd  out  1  one-cycle read strobe
- reg_ridx  out  IW  read register index, held until rdata is captured
- reg_rdata  in  DW  register read data

## Operation
- Decode: off = addr − BASE (modulo 2^AW); idx = off[AW-1:log2(DW/8)]; hit = idx < NREG. Byte-offset bits are ignored. Miss → no strobe, resp 2'b10 (SLVERR); hit → 2'b00.
- Write FSM, states W_IDLE, W_EXEC, W_RESP:
  - W_IDLE: awready = !aw_held, wready = !w_held. Each handshake latches its payload and sets its held flag; AW and W may complete in either order or in the same cycle. When both flags are set (including flags set this cycle) → W_EXEC.
  - W_EXEC, one cycle: reg_wr = hit; reg_widx, reg_wdata and reg_wstrb driven from the latches; bresp registered → W_RESP.
  - W_RESP: bvalid = 1 until bready; on handshake clear both flags → W_IDLE.
  - awready and wready are 0 in W_EXEC and W_RESP.
- Read FSM, states R_IDLE, R_STRB, R_WAIT, R_RESP:
  - R_IDLE: arready = 1. Handshake latches the index and hit flag → R_STRB.
  - R_STRB, one cycle: reg_rd = hit. If RD_LAT = 0, capture → R_RESP; otherwise → R_WAIT, loading a counter with RD_LAT−1.
  - R_WAIT: count down; at 0 capture → R_RESP.
  - Capture: rdata = hit ? reg_rdata : 0; rresp set from hit.
  - R_RESP: rvalid = 1 until rready → R_IDLE.
  - arready = 0 outside R_IDLE.
- The read and write paths are fully independent. A write and a read to the same index in the same cycle produce no ordering guarantee beyond AXI-Lite.
- rdata, rresp and bresp are stable while their valid is high.

## Timing
- Reset: all FSMs idle, held flags 0. awready = wready = arready = 1 from the first cycle after reset. bvalid, rvalid, reg_wr and reg_rd are 0. rdata, bresp, rresp, reg_wdata, reg_wstrb, reg_widx and reg_ridx are 0.
- Write, AW and W both handshake in cycle N: reg_wr in cycle N+1, bvalid rises in N+2. With AW at N and W at M > N, N is replaced by M.
- Read, handshake in cycle N: reg_rd in N+1, reg_rdata sampled in N+1+RD_LAT, rvalid rises in N+2+RD_LAT.
- Back-to-back: awready, wready and arready reassert in the cycle after the response handshake, so write throughput is 1 per 3 cycles and read throughput is 1 per 3+RD_LAT cycles with bready/rready held high.
- Reset asserted mid-transaction: every FSM returns to idle on the next edge. The pending transaction is dropped with no response and no strobe.
- No combinational path from any valid/ready input to any output.

## Test plan
- Write 0xA5A5_0001 to BASE+0x8 (DW=32), wstrb 4'hF, AW and W both in cycle 0 → reg_wr in cycle 1 with reg_widx=2, bvalid in cycle 2, bresp=00.
- W handshake at cycle 0 and AW at cycle 3, wstrb 4'b0101 → exactly one reg_wr, in cycle 4, with reg_wstrb=4'b0101; wready stays 0 after the W handshake until bready.
- RD_LAT=2, read BASE+0x4 with reg_rdata = 0x1234 from cycle 3 → reg_rd in cycle 1 with reg_ridx=1, rvalid in cycle 4, rdata=0x1234, rresp=00.
- NREG=16, write and read at BASE+0x40 → no reg_wr or reg_rd; bresp=10 and rresp=10; rdata=0.
- Hold bready and rready low for 5 cycles while a write and a read are outstanding together → bvalid and rvalid stay high with stable payloads; arready, awready and wready stay 0.
- Assert rst in the cycle after the AW+W handshake → no reg_wr and no bvalid; awready is 1 the cycle after rst deasserts.
